// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16-word RAM; one access per two cycles.
// Optional CLEAR_ON_RESET_EN: after reset an INIT phase writes zero to every RAM word before serving requests.
module ram_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {INIT, IDLE, ACCESS} state_t;
  localparam state_t RESET_STATE = INIT;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`else
  typedef enum logic [1:0] {IDLE, ACCESS} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              cmd_port_q, cmd_port_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      last_q      <= 1'b1;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef CLEAR_ON_RESET_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef CLEAR_ON_RESET_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  // Port 1 wins only when port 0 is idle or port 0 was the last one served.
  assign pick1 = req1 && (!req0 || !last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifdef CLEAR_ON_RESET_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
`ifdef CLEAR_ON_RESET_EN
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = IDLE;
      end
`endif
      IDLE: begin
        if (req0 || req1) begin
          cmd_port_d  = pick1;
          cmd_we_d    = pick1 ? we1 : we0;
          cmd_addr_d  = pick1 ? addr1 : addr0;
          cmd_wdata_d = pick1 ? wdata1 : wdata0;
          last_d      = pick1;
          gnt0_d      = !pick1;
          gnt1_d      = pick1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (!cmd_we_q) begin
          if (cmd_port_q) begin
            rdata1_d  = ram_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = ram_rdata;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM write strobe is masked by rst directly so a reset edge never commits a write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cmd_addr_q;
    ram_wdata = cmd_wdata_q;
    busy      = (state_q != IDLE);
    case (state_q)
      ACCESS: ram_we = cmd_we_q & ~rst;
`ifdef CLEAR_ON_RESET_EN
      INIT: begin
        ram_we    = ~rst;
        ram_addr  = init_cnt_q;
        ram_wdata = '0;
      end
`endif
      default: ram_we = 1'b0;
    endcase
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a transaction-level reference model.
module tb_ram_arbiter;
  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  bit            ref_known [16];
  int            rr_last;
  logic [DW-1:0] ref_rdata [2];
  bit            ref_rd_known [2];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    rr_last = 1;
    for (int p = 0; p < 2; p++) begin
      ref_rdata[p]    = '0;
      ref_rd_known[p] = 1'b1;
    end
`ifdef CLEAR_ON_RESET_EN
    for (int a = 0; a < 16; a++) begin
      ref_mem[a]   = '0;
      ref_known[a] = 1'b1;
    end
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc();
    rst = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    repeat (16) @(posedge clk);
    @(negedge clk);
`endif
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", gnt0, gnt1); end
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", rvalid0, rvalid1); end
    checks++; if (rdata0 !== 4'h0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    checks++; if (rdata1 !== 4'h0) begin errors++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
`ifdef CLEAR_ON_RESET_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`endif
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 4'hA;
    cyc();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== 4'd5 || ram_wdata !== 4'hA) begin errors++; $display("FAIL wr_ram got we=%b a=%h d=%h exp we=1 a=5 d=a", ram_we, ram_addr, ram_wdata); end
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5; wdata1 = 4'h3;
    cyc();
    checks++; if (gnt1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_idle got gnt1=%b busy=%b exp 0 0", gnt1, busy); end
    cyc();
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rd_gnt got gnt=%b%b we=%b exp gnt=01 we=0", gnt0, gnt1, ram_we); end
    req1 = 1'b0;
    cyc();
    checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_rvalid got=%b%b exp=01", rvalid0, rvalid1); end
    checks++; if (rdata1 !== 4'hA) begin errors++; $display("FAIL rd_rdata1 got=%h exp=a", rdata1); end
    cyc();
    checks++; if (rvalid1 !== 1'b0 || rdata1 !== 4'hA) begin errors++; $display("FAIL rd_hold got rvalid1=%b rdata1=%h exp 0 a", rvalid1, rdata1); end
  endtask

  task automatic test_round_robin();
    int n0, n1;
    do_reset();
    n0 = 0; n1 = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int c = 0; c < 8; c++) begin
      cyc();
      checks++; if (gnt0 !== (c % 4 == 0) || gnt1 !== (c % 4 == 2)) begin errors++; $display("FAIL rr_gnt c=%0d got=%b%b exp=%b%b", c, gnt0, gnt1, (c % 4 == 0), (c % 4 == 2)); end
      n0 += int'(gnt0); n1 += int'(gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++; if (n0 != 2 || n1 != 2) begin errors++; $display("FAIL rr_count got=%0d,%0d exp=2,2", n0, n1); end
    cyc(); cyc();
  endtask

  task automatic test_single_port();
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
    for (int c = 0; c < 8; c++) begin
      cyc();
      checks++; if (gnt1 !== (c % 2 == 0) || gnt0 !== 1'b0) begin errors++; $display("FAIL single_gnt c=%0d got=%b%b exp=0%b", c, gnt0, gnt1, (c % 2 == 0)); end
    end
    req1 = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_reset_during_write();
    logic [DW-1:0] exp_d;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 4'h6;
    cyc();
    req0 = 1'b0;
    cyc();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 4'h9;
    cyc();
    checks++; if (gnt0 !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL rstwr_pre got gnt0=%b we=%b exp 1 1", gnt0, ram_we); end
    rst = 1'b1; req0 = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rstwr_we_gated got=%b exp=0", ram_we); end
    @(negedge clk);
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL rstwr_outs got gnt=%b%b rv=%b%b exp all 0", gnt0, gnt1, rvalid0, rvalid1); end
    rst = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    repeat (16) @(posedge clk);
    @(negedge clk);
    exp_d = 4'h0;
`else
    exp_d = 4'h6;
`endif
    model_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    cyc();
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rstwr_rd_gnt got=%b exp=1", gnt1); end
    req1 = 1'b0;
    cyc();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== exp_d) begin errors++; $display("FAIL rstwr_rdata got rv=%b d=%h exp rv=1 d=%h", rvalid1, rdata1, exp_d); end
  endtask

  task automatic test_random();
    bit            act [2];
    logic          pwe [2];
    logic [AW-1:0] pad [2];
    logic [DW-1:0] pwd [2];
    int            w;
    do_reset();
    for (int p = 0; p < 2; p++) act[p] = 1'b0;
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(1) == 1) begin
          act[p] = 1'b1;
          pwe[p] = 1'($urandom_range(1));
          pad[p] = 4'($urandom_range(15));
          pwd[p] = 4'($urandom_range(15));
        end
      end
      if (!act[0] && !act[1]) begin
        w = int'($urandom_range(1));
        act[w] = 1'b1;
        pwe[w] = 1'b0;
        pad[w] = 4'($urandom_range(15));
        pwd[w] = 4'($urandom_range(15));
      end
      req0 = act[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pwd[0];
      req1 = act[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pwd[1];
      if (act[0] && act[1]) w = 1 - rr_last;
      else w = act[1] ? 1 : 0;
      rr_last = w;
      cyc();
      checks++; if (gnt0 !== (w == 0) || gnt1 !== (w == 1)) begin errors++; $display("FAIL rnd_gnt r=%0d got=%b%b exp port %0d", r, gnt0, gnt1, w); end
      checks++; if (ram_we !== pwe[w] || ram_addr !== pad[w] || (pwe[w] && ram_wdata !== pwd[w])) begin errors++; $display("FAIL rnd_ram r=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h", r, ram_we, ram_addr, ram_wdata, pwe[w], pad[w], pwd[w]); end
      if (pwe[w]) begin
        ref_mem[pad[w]]   = pwd[w];
        ref_known[pad[w]] = 1'b1;
      end else begin
        ref_rdata[w]    = ref_mem[pad[w]];
        ref_rd_known[w] = ref_known[pad[w]];
      end
      act[w] = 1'b0;
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      cyc();
      checks++; if (rvalid0 !== (w == 0 && !pwe[w]) || rvalid1 !== (w == 1 && !pwe[w])) begin errors++; $display("FAIL rnd_rvalid r=%0d got=%b%b port=%0d we=%b", r, rvalid0, rvalid1, w, pwe[w]); end
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_idle r=%0d got gnt=%b%b busy=%b exp 0", r, gnt0, gnt1, busy); end
      if (ref_rd_known[0]) begin
        checks++; if (rdata0 !== ref_rdata[0]) begin errors++; $display("FAIL rnd_rdata0 r=%0d got=%h exp=%h", r, rdata0, ref_rdata[0]); end
      end
      if (ref_rd_known[1]) begin
        checks++; if (rdata1 !== ref_rdata[1]) begin errors++; $display("FAIL rnd_rdata1 r=%0d got=%h exp=%h", r, rdata1, ref_rdata[1]); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc();
  endtask

`ifdef CLEAR_ON_RESET_EN
  task automatic test_init();
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd15; wdata0 = 4'hC;
    cyc();
    req0 = 1'b0;
    cyc();
    rst = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 4'd15;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) || ram_wdata !== 4'h0 || gnt0 !== 1'b0) begin errors++; $display("FAIL init_step i=%0d got busy=%b we=%b a=%h d=%h gnt0=%b", i, busy, ram_we, ram_addr, ram_wdata, gnt0); end
      cyc();
    end
    checks++; if (busy !== 1'b0 || ram_we !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL init_done got busy=%b we=%b gnt0=%b exp 0 0 0", busy, ram_we, gnt0); end
    cyc();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL init_gnt0 got=%b exp=1", gnt0); end
    req0 = 1'b0;
    cyc();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 4'h0) begin errors++; $display("FAIL init_rdata0 got rv=%b d=%h exp rv=1 d=0", rvalid0, rdata0); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a]   = '0;
      ref_known[a] = 1'b0;
    end
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_round_robin();
    test_single_port();
    test_reset_during_write();
    test_random();
`ifdef CLEAR_ON_RESET_EN
    test_init();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_W, 4, RAM word width in bits.
REQ-002 Parameter: ADDR_W, 4, RAM address width in bits (16 words).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 Port: we0 / we1  input  1  1 = write, 0 = read; valid while reqN=1.
REQ-007 Port: addr0 / addr1  input  ADDR_W  target address; valid while reqN=1.
REQ-008 Port: wdata0 / wdata1  input  DATA_W  write data; valid while reqN=1.
REQ-009 Port: gnt0 / gnt1  output  1  one-cycle grant pulse; command accepted.
REQ-010 Port: rvalid0 / rvalid1  output  1  one-cycle pulse; rdataN holds new read data.
REQ-011 Port: rdata0 / rdata1  output  DATA_W  registered read data per requester.
REQ-012 Port: ram_we  output  1  write enable to the 16-word RAM.
REQ-013 Port: ram_addr  output  ADDR_W  RAM address.
REQ-014 Port: ram_wdata  output  DATA_W  RAM write data.
REQ-015 Port: ram_rdata  input  DATA_W  RAM combinational read data for ram_addr.
REQ-016 Port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be INIT, IDLE and ACCESS; INIT exists only with CLEAR_ON_RESET_EN.
REQ-018 In IDLE with any reqN=1, the edge SHALL latch the winner's we/addr/wdata, pulse gntN for the next cycle, and enter ACCESS.
REQ-019 Arbitration SHALL be round-robin: single requester always wins; if both request, the winner is the port not granted last; last-granted resets to 1, so port 0 wins first.
REQ-020 In ACCESS (exactly one cycle), ram_addr/ram_wdata/ram_we SHALL be driven from the latched command; the state then returns to IDLE.
REQ-021 For a read, ram_rdata SHALL be captured into rdataN at the end of ACCESS, with rvalidN=1 for the following cycle only; writes SHALL produce no rvalid.
REQ-022 rdataN SHALL hold its value until the next read completes on that port.
REQ-023 ram_we SHALL be 0 in IDLE, and in ACCESS for reads; ram_addr/ram_wdata are don't-care while ram_we=0.
REQ-024 Requesters SHALL hold reqN and command stable until gntN is seen, then drop reqN; sustained throughput is one access per 2 cycles.
REQ-025 A reqN still high in the IDLE cycle after its grant SHALL be treated as a new request.
REQ-026 gnt0 and gnt1 SHALL never be 1 in the same cycle; likewise for rvalid0/rvalid1.
REQ-027 Address and data SHALL pass unmodified; there is no address wrap or arithmetic outside the INIT counter.

Reset
REQ-028 On rst=1 at an edge: state -> INIT (macro defined) or IDLE; gntN=0, rvalidN=0, rdataN=0, last-granted=1, INIT counter=0.
REQ-029 ram_we SHALL be gated low combinationally while rst=1, so that an ACCESS interrupted by reset does not write the RAM.
REQ-030 A command granted but interrupted by reset SHALL be discarded, with no rvalid issued.

Configuration
REQ-031 With CLEAR_ON_RESET_EN defined: after reset, INIT SHALL write 0 to addresses 0..15 in 16 consecutive cycles (ram_we=1, ram_addr=counter, ram_wdata=0), with busy=1, no grants and requests held pending, then go to IDLE.
REQ-032 Without CLEAR_ON_RESET_EN: reset SHALL go directly to IDLE, and RAM contents are undefined until written.

Verification
REQ-033 Port-0 write addr=5 data=0xA, then port-1 read addr=5 -> gnt0, then gnt1, then rvalid1=1 with rdata1=0xA two cycles after its request was sampled.
REQ-034 req0 and req1 both held high for 4 accesses -> grants alternate 0,1,0,1, with one gnt every 2 cycles and never simultaneous.
REQ-035 Only req1 asserted repeatedly -> port 1 is granted on every IDLE cycle, with no starvation caused by the round-robin pointer.
REQ-036 rst asserted during ACCESS of a write to addr 3 (old 0x6) -> ram_we=0 on that edge; a later read of addr 3 returns 0x6, and there is no rvalid or gnt on the reset edge.
REQ-037 With CLEAR_ON_RESET_EN, release rst with req0 read addr=15 pending -> 16 INIT writes of 0, busy=1 for 16 cycles, then gnt0 and rdata0=0x0.
